// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: hazard FSM state encoding, register
// address width and the memory-wait watchdog limit.
package cpu_pipe_pkg;

  localparam int         REG_AW   = 6;
  localparam logic [7:0] WAIT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } hz_state_e;

  // One bundle of pipeline-register controls produced per cycle.
  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exmem_hold;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
module hazard_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count qualifying cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirect
// flushes and data-memory wait stalls, with a sticky wait watchdog.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating
// stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memRead,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_hold,
  output logic              idex_flush,
  output logic              exmem_hold,
  output logic [1:0]        state,
  output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam hz_ctrl_t CTRL_HOLD_ALL = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                         idex_hold: 1'b1, idex_flush: 1'b0, exmem_hold: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH    = '{pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                         idex_hold: 1'b0, idex_flush: 1'b1, exmem_hold: 1'b0};
  localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                         idex_hold: 1'b0, idex_flush: 1'b1, exmem_hold: 1'b0};

  hz_state_e  state_q, state_d;
  logic       pend_q, pend_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q;
  hz_ctrl_t   ctrl_c;
  hz_ctrl_t   ctrl_out;

  logic load_use;
  logic mem_stall;

  assign load_use  = id_valid & ex_memRead & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mem_stall = mem_req & ~mem_ready;

  // Next-state and Mealy control decode; priority mem_stall > redirect > load_use.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    ctrl_c     = '0;
    state_d    = state_q;
    pend_d     = pend_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl_c     = CTRL_HOLD_ALL;
          state_d    = ST_MEM_WAIT;
          pend_d     = ex_redirect;
          wait_cnt_d = '0;
        end else if (ex_redirect) begin
          ctrl_c = CTRL_FLUSH;
        end else if (load_use) begin
          ctrl_c = CTRL_LOAD_USE;
        end
      end
      ST_MEM_WAIT: begin
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
        // A redirect resolved during the wait must not be lost; it is replayed after.
        pend_d     = pend_q | ex_redirect;
        if (mem_stall) begin
          ctrl_c = CTRL_HOLD_ALL;
        end else begin
          state_d = (pend_q | ex_redirect) ? ST_REDIRECT : ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (mem_stall) begin
          ctrl_c     = CTRL_HOLD_ALL;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          ctrl_c  = CTRL_FLUSH;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        pend_d     = 1'b0;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output shaping: flush beats hold on the same register, and reset silences everything.
  always_comb begin
    ctrl_out           = ctrl_c;
    ctrl_out.ifid_hold = ctrl_c.ifid_hold & ~ctrl_c.ifid_flush;
    ctrl_out.idex_hold = ctrl_c.idex_hold & ~ctrl_c.idex_flush;
    // Outputs are combinational from inputs, so the async reset must also gate them directly.
    if (rst) begin
      ctrl_out = '0;
    end
  end

  // State, pending redirect, wait counter and sticky watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pend_q     <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      pend_q     <= pend_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | (wait_cnt_d == WAIT_MAX);
    end
  end

  assign pc_hold     = ctrl_out.pc_hold;
  assign ifid_hold   = ctrl_out.ifid_hold;
  assign ifid_flush  = ctrl_out.ifid_flush;
  assign idex_hold   = ctrl_out.idex_hold;
  assign idex_flush  = ctrl_out.idex_flush;
  assign exmem_hold  = ctrl_out.exmem_hold;
  assign state       = state_q;
  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ctrl_out.pc_hold),
    .cnt_o (stall_cnt)
  );

  hazard_perf_cnt #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ctrl_out.idex_flush),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 The ports SHALL be as follows:
- clk  in  1  pipeline clock.
- rst  in  1  async active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  6 each  ID source register numbers.
- ex_rd  in  6  EX destination register.
- ex_memRead  in  1  EX instruction is a load.
- ex_redirect  in  1  EX branch taken, jump or jumpMem resolved this cycle.
- mem_req  in  1  MEM stage accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its contents.
- ifid_flush  out  1  IF/ID loads a bubble.
- idex_hold  out  1  ID/EX keeps its contents.
- idex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- exmem_hold  out  1  EX/MEM keeps its contents.
- state  out  2  current FSM state, for debug.
- mem_timeout  out  1  sticky wait-watchdog flag.

Function
REQ-003 FSM states SHALL be RUN=0, MEM_WAIT=1 and REDIRECT=2; 3 is illegal and SHALL go to RUN on the next clock with all outputs 0.
REQ-004 A load-use hazard SHALL be defined as load_use = id_valid & ex_memRead & (ex_rd==id_rs1 | ex_rd==id_rs2); register 0 is not special.
REQ-005 A memory stall SHALL be defined as mem_stall = mem_req & ~mem_ready.
REQ-006 Outputs SHALL be combinational from state and inputs (Mealy), and only one class of action SHALL apply per cycle, with priority mem_stall > redirect > load_use.
REQ-007 In RUN with mem_stall:
- pc_hold, ifid_hold, idex_hold and exmem_hold SHALL be 1 and both flushes 0.
- next state SHALL be MEM_WAIT.
- pend_redirect SHALL be set to ex_redirect.
REQ-008 In RUN with ex_redirect and no mem_stall, ifid_flush and idex_flush SHALL be 1, no hold SHALL be asserted, and the FSM SHALL stay in RUN (2-cycle penalty).
REQ-009 In RUN with load_use only, pc_hold, ifid_hold and idex_flush SHALL be 1 for exactly that cycle, and the FSM SHALL stay in RUN.
REQ-010 In MEM_WAIT, all four holds SHALL be 1 while mem_stall is 1; load_use and ex_redirect SHALL be ignored except that ex_redirect=1 sets pend_redirect.
REQ-011 In MEM_WAIT, when mem_ready=1 the holds SHALL drop that cycle; the next state SHALL be REDIRECT if pend_redirect is set, otherwise RUN.
REQ-012 REDIRECT SHALL last one cycle: ifid_flush=1, idex_flush=1, pend_redirect cleared, next state RUN; a mem_stall in this cycle SHALL take priority and go to MEM_WAIT with pend_redirect kept.
REQ-013 An 8-bit wait counter SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle, saturating at 255.
REQ-014 mem_timeout SHALL set when the wait counter reaches 255 and stay set until reset.
REQ-015 hold and flush of the same register SHALL never be 1 together; if that arises, flush SHALL win.

Reset
REQ-016 While rst=1, the block SHALL be in state RUN with pend_redirect=0, the wait counter 0, mem_timeout 0 and every output 0, asynchronously.
REQ-017 Reset asserted mid-MEM_WAIT SHALL abandon the wait and discard any pending redirect.

Configuration
REQ-018 With HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[15:0] (cycles with pc_hold=1) and flush_cnt[15:0] (cycles with idex_flush=1); both SHALL saturate at 0xFFFF and reset to 0.
REQ-019 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-020 The state encoding, REG_AW=6 and WAIT_MAX=255 SHALL live in the shared package cpu_pipe_pkg.
REQ-021 The perf counters SHALL be one sub-module, hazard_perf_cnt, instantiated twice under the macro.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_valid=1 -> one cycle of pc_hold=1, ifid_hold=1, idex_flush=1, then all 0.
- Redirect: ex_redirect=1 in RUN -> ifid_flush=1 and idex_flush=1 for one cycle; state stays 0.
- Wait with redirect: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 in the first -> holds high 3 cycles; REDIRECT flushes on the cycle after mem_ready=1.
- Priority: mem_stall, load_use and ex_redirect together -> holds only, no flush.
- Timeout: mem_ready held 0 for 260 cycles -> mem_timeout=1 from the 256th wait cycle; rst clears it.
- Reset: rst pulsed mid-MEM_WAIT -> state=0 and all outputs 0 immediately; no later flush.
